// File: rtl/sobel_edge_pkg.sv
// Shared widths, constants and small arithmetic helpers for the Sobel edge
// pipeline. The bench uses PIPE_LAT to check output timing.
package sobel_edge_pkg;

    localparam int PIX_W    = 8;
    localparam int GRAD_W   = 11;
    localparam int PIPE_LAT = 3;
    localparam logic [PIX_W-1:0] SAT_MAX = 8'd255;

    // Three taps of a Sobel kernel row or column, weighted 1-2-1.
    typedef struct packed {
        logic [PIX_W-1:0] a;
        logic [PIX_W-1:0] b;
        logic [PIX_W-1:0] c;
    } tap3_t;

    function automatic logic [GRAD_W-1:0] tap_sum(input tap3_t t);
        return GRAD_W'(t.a) + GRAD_W'({t.b, 1'b0}) + GRAD_W'(t.c);
    endfunction

    function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] v);
        return v[GRAD_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [PIX_W-1:0] sat_pix(input logic [GRAD_W-1:0] m);
        return (m > GRAD_W'(SAT_MAX)) ? SAT_MAX : m[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: simple dual-port RAM with registered read, read-before-write
// when both ports hit the same address. Only the read register is reset.
module sobel_line_buffer
    import sobel_edge_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [PIX_W-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [PIX_W-1:0]  o_rd_data
);

    logic [PIX_W-1:0] r_mem [0:DEPTH-1];
    logic [PIX_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
    end

    // The read register doubles as a window register upstream, so it is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rd_data <= '0;
        else if (i_rd_en)
            r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sobel_edge.sv
// 3x3 Sobel edge detector on an 8-bit luma raster stream: two line buffers,
// saturated |Gx|+|Gy| magnitude and thresholded edge bit, fixed 3-cycle latency.
module sobel_edge
    import sobel_edge_pkg::*;
#(
    parameter int         IMG_W  = 640,
    parameter int         IMG_H  = 480,
    parameter logic [7:0] THRESH = 8'd64,
    parameter int         COL_W  = $clog2(IMG_W),
    parameter int         ROW_W  = $clog2(IMG_H)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] y_in,
    input  logic             y_valid,
    input  logic             y_sof,
    output logic [PIX_W-1:0] edge_mag,
    output logic             edge_bin,
    output logic             edge_valid,
    output logic             edge_sof
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] r_col, w_cur_col, w_next_col;
    logic [ROW_W-1:0] r_row, w_cur_row, w_next_row;

    // sof overrides the counters, which also makes it win over any wrap.
    always_comb begin
        w_cur_col  = y_sof ? '0 : r_col;
        w_cur_row  = y_sof ? '0 : r_row;
        w_next_col = w_cur_col + 1'b1;
        w_next_row = w_cur_row;
        if (w_cur_col == COL_LAST) begin
            w_next_col = '0;
            w_next_row = (w_cur_row == ROW_LAST) ? '0 : w_cur_row + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (y_valid) begin
            r_col <= w_next_col;
            r_row <= w_next_row;
        end
    end

    // Valid/sof shift registers: no backpressure, gaps pass through unchanged.
    logic [PIPE_LAT-1:0] r_vld_sr;
    logic [PIPE_LAT-1:0] r_sof_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_sr <= '0;
            r_sof_sr <= '0;
        end else begin
            r_vld_sr <= {r_vld_sr[PIPE_LAT-2:0], y_valid};
            r_sof_sr <= {r_sof_sr[PIPE_LAT-2:0], y_valid & y_sof};
        end
    end

    // Stage 1: line buffer reads, window shift, position latch.
    logic [PIX_W-1:0] w_lb0_q, w_lb1_q;
    logic [PIX_W-1:0] r_y;
    logic [COL_W-1:0] r_s1_col;
    logic             r_s1_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y       <= '0;
            r_s1_col  <= '0;
            r_s1_mask <= 1'b0;
        end else if (y_valid) begin
            r_y       <= y_in;
            r_s1_col  <= w_cur_col;
            r_s1_mask <= (w_cur_row < ROW_W'(2)) || (w_cur_col < COL_W'(2));
        end
    end

    sobel_line_buffer #(
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (y_valid),
        .i_wr_addr (w_cur_col),
        .i_wr_data (y_in),
        .i_rd_en   (y_valid),
        .i_rd_addr (w_cur_col),
        .o_rd_data (w_lb0_q)
    );

    // Row-2 store is fed from lb0's registered read one cycle later, at the
    // latched column; that column is not read again until the next line.
    sobel_line_buffer #(
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (r_vld_sr[0]),
        .i_wr_addr (r_s1_col),
        .i_wr_data (w_lb0_q),
        .i_rd_en   (y_valid),
        .i_rd_addr (w_cur_col),
        .o_rd_data (w_lb1_q)
    );

    // Right window column is the line buffer read registers plus r_y;
    // index 0 is the oldest row.
    logic [2:0][PIX_W-1:0] w_win_c2;
    assign w_win_c2 = {r_y, w_lb0_q, w_lb1_q};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win
            logic [PIX_W-1:0] r_c0;
            logic [PIX_W-1:0] r_c1;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_c0 <= '0;
                    r_c1 <= '0;
                end else if (y_valid) begin
                    r_c1 <= w_win_c2[gi];
                    r_c0 <= r_c1;
                end
            end
        end
    endgenerate

    // Stage 2: signed gradients, masked at the top/left border.
    tap3_t w_left, w_right, w_top, w_bot;
    logic signed [GRAD_W-1:0] w_gx, w_gy;
    logic signed [GRAD_W-1:0] r_gx, r_gy;

    always_comb begin
        w_left  = '{a: g_win[0].r_c0, b: g_win[1].r_c0, c: g_win[2].r_c0};
        w_right = '{a: w_win_c2[0],   b: w_win_c2[1],   c: w_win_c2[2]};
        w_top   = '{a: g_win[0].r_c0, b: g_win[0].r_c1, c: w_win_c2[0]};
        w_bot   = '{a: g_win[2].r_c0, b: g_win[2].r_c1, c: w_win_c2[2]};
        w_gx    = $signed(tap_sum(w_right) - tap_sum(w_left));
        w_gy    = $signed(tap_sum(w_bot) - tap_sum(w_top));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gx <= '0;
            r_gy <= '0;
        end else if (r_vld_sr[0]) begin
            r_gx <= r_s1_mask ? '0 : w_gx;
            r_gy <= r_s1_mask ? '0 : w_gy;
        end
    end

    // Stage 3: magnitude, saturation and threshold.
    logic [GRAD_W-1:0] w_mag;
    logic [PIX_W-1:0]  w_sat;
    logic [PIX_W-1:0]  r_mag;
    logic              r_bin;

    assign w_mag = abs_grad(r_gx) + abs_grad(r_gy);
    assign w_sat = sat_pix(w_mag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag <= '0;
            r_bin <= 1'b0;
        end else if (r_vld_sr[1]) begin
            r_mag <= w_sat;
            r_bin <= (w_sat >= THRESH);
        end
    end

    assign edge_mag   = r_mag;
    assign edge_bin   = r_bin;
    assign edge_valid = r_vld_sr[PIPE_LAT-1];
    assign edge_sof   = r_sof_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_sobel_edge.sv
// Scoreboard bench for sobel_edge on an 8x6 image; two instances share the
// stream and differ only in THRESH (64 and 40).
`timescale 1ns/1ps
module tb_sobel_edge;
    import sobel_edge_pkg::*;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] y_in = 8'd0;
    logic       y_valid = 1'b0;
    logic       y_sof = 1'b0;
    logic [7:0] edge_mag, b_mag;
    logic       edge_bin, edge_valid, edge_sof;
    logic       b_bin, b_valid, b_sof;

    always #5 clk = ~clk;

    sobel_edge #(.IMG_W(W), .IMG_H(H), .THRESH(8'd64)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .y_sof(y_sof),
        .edge_mag(edge_mag), .edge_bin(edge_bin), .edge_valid(edge_valid), .edge_sof(edge_sof)
    );

    sobel_edge #(.IMG_W(W), .IMG_H(H), .THRESH(8'd40)) dut_t40 (
        .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .y_sof(y_sof),
        .edge_mag(b_mag), .edge_bin(b_bin), .edge_valid(b_valid), .edge_sof(b_sof)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int mag;
        bit b64;
        bit b40;
        bit sof;
        int stamp;
        int r;
        int c;
    } exp_t;

    exp_t exp_q[$];
    int   img [0:H-1][0:W-1];
    int   m_r = 0;
    int   m_c = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   run_pulses, run_sofs, run_b64, run_b40;

    function automatic int pix_of(input int pat, input int r, input int c);
        case (pat)
            0:       return 100;
            1:       return (c >= 4) ? 255 : 0;
            2:       return (r >= 3) ? 10 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Golden model: output for pixel (r,c) is the Sobel value centred at (r-1,c-1).
    task automatic model_push(input int pix, input bit sof);
        exp_t e;
        int gx, gy, mag;
        if (sof) begin
            m_r = 0;
            m_c = 0;
        end
        img[m_r][m_c] = pix;
        mag = 0;
        if (m_r >= 2 && m_c >= 2) begin
            gx = (img[m_r-2][m_c] + 2*img[m_r-1][m_c] + img[m_r][m_c])
               - (img[m_r-2][m_c-2] + 2*img[m_r-1][m_c-2] + img[m_r][m_c-2]);
            gy = (img[m_r][m_c-2] + 2*img[m_r][m_c-1] + img[m_r][m_c])
               - (img[m_r-2][m_c-2] + 2*img[m_r-2][m_c-1] + img[m_r-2][m_c]);
            mag = iabs(gx) + iabs(gy);
            if (mag > 255) mag = 255;
        end
        e.mag = mag; e.b64 = (mag >= 64); e.b40 = (mag >= 40);
        e.sof = sof; e.stamp = cyc; e.r = m_r; e.c = m_c;
        exp_q.push_back(e);
        if (m_c == W-1) begin
            m_c = 0;
            m_r = (m_r == H-1) ? 0 : m_r + 1;
        end else begin
            m_c++;
        end
    endtask

    // One clock: compare whatever the DUT shows, then drive the next input.
    task automatic step_cycle(input bit v, input int pix, input bit sof);
        exp_t e;
        @(posedge clk);
        #1;
        n_checks++;
        if (b_valid !== edge_valid) begin
            n_fail++;
            $display("FAIL valid_pair cyc=%0d thr40_valid=%b required %b", cyc, b_valid, edge_valid);
        end
        if (edge_valid === 1'b1) begin
            run_pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output cyc=%0d mag=%0d required no output", cyc, edge_mag);
            end else begin
                e = exp_q.pop_front();
                run_sofs += int'(edge_sof);
                run_b64  += int'(edge_bin);
                run_b40  += int'(b_bin);
                $display("out cyc=%0d r=%0d c=%0d mag=%0d bin=%b bin40=%b sof=%b",
                         cyc, e.r, e.c, edge_mag, edge_bin, b_bin, edge_sof);
                if (edge_mag !== e.mag[7:0] || b_mag !== e.mag[7:0] || edge_bin !== e.b64 ||
                    b_bin !== e.b40 || edge_sof !== e.sof) begin
                    n_fail++;
                    $display("FAIL result r=%0d c=%0d got mag=%0d/%0d bin=%b bin40=%b sof=%b required mag=%0d bin=%b bin40=%b sof=%b",
                             e.r, e.c, edge_mag, b_mag, edge_bin, b_bin, edge_sof, e.mag, e.b64, e.b40, e.sof);
                end
                n_checks++;
                if (cyc - e.stamp != PIPE_LAT) begin
                    n_fail++;
                    $display("FAIL latency r=%0d c=%0d got %0d required %0d", e.r, e.c, cyc - e.stamp, PIPE_LAT);
                end
            end
        end
        y_valid = v;
        y_in    = v ? pix[7:0] : 8'd0;
        y_sof   = v & sof;
        if (v) model_push(pix, sof);
    endtask

    task automatic run_stream(input int pat, input int npix, input int gap_pct, input bit drain);
        int r = 0;
        int c = 0;
        run_pulses = 0; run_sofs = 0; run_b64 = 0; run_b40 = 0;
        for (int i = 0; i < npix; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) step_cycle(1'b0, 0, 1'b0);
            step_cycle(1'b1, pix_of(pat, r, c), i == 0);
            if (c == W-1) begin c = 0; r++; end else c++;
        end
        if (drain) begin
            for (int k = 0; k < 8 && exp_q.size() > 0; k++) step_cycle(1'b0, 0, 1'b0);
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
                exp_q.delete();
            end
            repeat (3) step_cycle(1'b0, 0, 1'b0);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (edge_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b required 0", edge_valid); end
        n_checks++;
        if (edge_mag !== 8'd0) begin n_fail++; $display("FAIL reset_mag got %0d required 0", edge_mag); end
        n_checks++;
        if (edge_bin !== 1'b0) begin n_fail++; $display("FAIL reset_bin got %b required 0", edge_bin); end
        n_checks++;
        if (edge_sof !== 1'b0) begin n_fail++; $display("FAIL reset_sof got %b required 0", edge_sof); end
        rst = 1'b0;
    endtask

    task automatic test_flat();
        run_stream(0, W*H, 0, 1'b1);
        n_checks++;
        if (run_pulses != 48) begin n_fail++; $display("FAIL flat_count got %0d required 48", run_pulses); end
        n_checks++;
        if (run_sofs != 1) begin n_fail++; $display("FAIL flat_sof_count got %0d required 1", run_sofs); end
        n_checks++;
        if (run_b64 != 0) begin n_fail++; $display("FAIL flat_edges got %0d required 0", run_b64); end
    endtask

    task automatic test_vstep();
        run_stream(1, W*H, 0, 1'b1);
        n_checks++;
        if (run_b64 != 8) begin n_fail++; $display("FAIL vstep_edges got %0d required 8", run_b64); end
    endtask

    task automatic test_hstep();
        run_stream(2, W*H, 0, 1'b1);
        n_checks++;
        if (run_b64 != 0) begin n_fail++; $display("FAIL hstep_edges64 got %0d required 0", run_b64); end
        n_checks++;
        if (run_b40 != 12) begin n_fail++; $display("FAIL hstep_edges40 got %0d required 12", run_b40); end
    endtask

    task automatic test_gaps();
        run_stream(1, W*H, 50, 1'b1);
        n_checks++;
        if (run_pulses != 48) begin n_fail++; $display("FAIL gaps_count got %0d required 48", run_pulses); end
        n_checks++;
        if (run_b64 != 8) begin n_fail++; $display("FAIL gaps_edges got %0d required 8", run_b64); end
    endtask

    task automatic test_restart();
        run_stream(1, 20, 0, 1'b0);
        run_stream(1, W*H, 0, 1'b1);
        n_checks++;
        if (run_pulses != 51) begin n_fail++; $display("FAIL restart_count got %0d required 51", run_pulses); end
        n_checks++;
        if (run_sofs != 1) begin n_fail++; $display("FAIL restart_sof_count got %0d required 1", run_sofs); end
        n_checks++;
        if (run_b64 != 8) begin n_fail++; $display("FAIL restart_edges got %0d required 8", run_b64); end
    endtask

    task automatic test_reset_midframe();
        run_stream(1, 20, 0, 1'b0);
        rst     = 1'b1;
        y_valid = 1'b0;
        y_sof   = 1'b0;
        #1;
        n_checks++;
        if (edge_valid !== 1'b0 || b_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_valid got %b/%b required 0", edge_valid, b_valid);
        end
        n_checks++;
        if (edge_mag !== 8'd0 || edge_sof !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs got mag=%0d sof=%b required 0", edge_mag, edge_sof);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (edge_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_hold got %b required 0", edge_valid); end
        end
        exp_q.delete();
        rst = 1'b0;
        run_pulses = 0;
        repeat (5) step_cycle(1'b0, 0, 1'b0);
        n_checks++;
        if (run_pulses != 0) begin n_fail++; $display("FAIL midreset_stale got %0d required 0", run_pulses); end
        run_stream(1, W*H, 0, 1'b1);
        n_checks++;
        if (run_pulses != 48) begin n_fail++; $display("FAIL midreset_count got %0d required 48", run_pulses); end
        n_checks++;
        if (run_b64 != 8) begin n_fail++; $display("FAIL midreset_edges got %0d required 8", run_b64); end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_vstep();
        test_hstep();
        test_gaps();
        test_restart();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
